// File: rtl/id_ex_operand_stage.sv
// ID/EX stage: captures regfile reads, forwards from EX/MEM and MEM/WB, and stalls on ALU/load-use hazards.
// Define HAZARD_STATS_EN to add saturating stall_cycles / flush_count counters.
module id_ex_operand_stage #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic [WIDTH-1:0] rf_data1,
    input  logic [WIDTH-1:0] rf_data2,
    input  logic             exmem_regwrite,
    input  logic             exmem_memread,
    input  logic [4:0]       exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_regwrite,
    input  logic [4:0]       memwb_rd,
    input  logic [WIDTH-1:0] memwb_data,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_opA,
    output logic [WIDTH-1:0] ex_opB,
    output logic [4:0]       ex_rd,
    output logic             ex_regwrite,
    output logic             ex_memread
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
`endif
);
    // Handshake: id_valid qualifies the decode fields; the instruction moves into EX on a rising
    // edge when id_valid && !stall && !flush, otherwise EX receives a bubble. ex_valid qualifies ex_*.
    localparam logic [4:0] ZR = 5'(ZERO_REG);

    logic             r_ex_valid;
    logic [WIDTH-1:0] r_ex_opa;
    logic [WIDTH-1:0] r_ex_opb;
    logic [4:0]       r_ex_rd;
    logic             r_ex_regwrite;
    logic             r_ex_memread;

    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_haz;

    // A producer matching a non-zero rs can never itself target the zero register.
    function automatic logic [WIDTH-1:0] sel_operand(
        input logic [4:0]       rs,
        input logic [WIDTH-1:0] rf,
        input logic             em_rw,
        input logic             em_mr,
        input logic [4:0]       em_rd,
        input logic [WIDTH-1:0] em_res,
        input logic             mw_rw,
        input logic [4:0]       mw_rd,
        input logic [WIDTH-1:0] mw_data
    );
        if (rs == ZR)
            return '0;
        else if (em_rw && !em_mr && (em_rd == rs))
            return em_res;
        else if (mw_rw && (mw_rd == rs))
            return mw_data;
        else
            return rf;
    endfunction

    always_comb begin
        w_opa = sel_operand(id_rs1, rf_data1, exmem_regwrite, exmem_memread, exmem_rd,
                            exmem_result, memwb_regwrite, memwb_rd, memwb_data);
        w_opb = sel_operand(id_rs2, rf_data2, exmem_regwrite, exmem_memread, exmem_rd,
                            exmem_result, memwb_regwrite, memwb_rd, memwb_data);
    end

    assign w_haz1 = id_rs1_used && (id_rs1 != ZR) &&
                    ((r_ex_valid && r_ex_regwrite && (r_ex_rd == id_rs1)) ||
                     (exmem_regwrite && exmem_memread && (exmem_rd == id_rs1)));
    assign w_haz2 = id_rs2_used && (id_rs2 != ZR) &&
                    ((r_ex_valid && r_ex_regwrite && (r_ex_rd == id_rs2)) ||
                     (exmem_regwrite && exmem_memread && (exmem_rd == id_rs2)));
    assign w_haz  = id_valid && (w_haz1 || w_haz2);
    assign stall  = w_haz && !flush;

    // Flush and stall both insert a bubble; operand registers keep their old contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_valid    <= 1'b0;
            r_ex_opa      <= '0;
            r_ex_opb      <= '0;
            r_ex_rd       <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
        end else if (flush || w_haz) begin
            r_ex_valid    <= 1'b0;
            r_ex_rd       <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
        end else begin
            r_ex_valid    <= id_valid;
            r_ex_rd       <= id_valid ? id_rd : 5'd0;
            r_ex_regwrite <= id_valid && id_regwrite;
            r_ex_memread  <= id_valid && id_memread;
            r_ex_opa      <= w_opa;
            r_ex_opb      <= w_opb;
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_opA      = r_ex_opa;
    assign ex_opB      = r_ex_opb;
    assign ex_rd       = r_ex_rd;
    assign ex_regwrite = r_ex_regwrite;
    assign ex_memread  = r_ex_memread;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (stall && (r_stall_cycles != 32'hFFFF_FFFF))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (flush && (r_flush_count != 32'hFFFF_FFFF))
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed hazard/forwarding cases, then a random program checked
// against an in-order architectural register model through an expected-result queue.
module tb_id_ex_operand_stage;
    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic [63:0] rf_data1;
    logic [63:0] rf_data2;
    logic        exmem_regwrite;
    logic        exmem_memread;
    logic [4:0]  exmem_rd;
    logic [63:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [63:0] memwb_data;
    logic        flush;
    logic        stall;
    logic        ex_valid;
    logic [63:0] ex_opA;
    logic [63:0] ex_opB;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
        .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    typedef struct packed {
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        ca;
        logic        cb;
        logic [63:0] a;
        logic [63:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic rw, input logic mr,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic ca, input logic cb);
        exp_t e;
        e.rd = rd; e.rw = rw; e.mr = mr; e.a = a; e.b = b; e.ca = ca; e.cb = cb;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per valid EX instruction
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (reset) begin
            if (ex_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ex: got ex_valid=1 rd=%0d expected no instruction", ex_rd);
                end else begin
                    e = exp_q.pop_front();
                    chk("ex_rd", 64'(ex_rd), 64'(e.rd));
                    chk("ex_regwrite", 64'(ex_regwrite), 64'(e.rw));
                    chk("ex_memread", 64'(ex_memread), 64'(e.mr));
                    if (e.ca) chk("ex_opA", ex_opA, e.a);
                    if (e.cb) chk("ex_opB", ex_opB, e.b);
                end
            end else begin
                chk("bubble_regwrite", 64'(ex_regwrite), 64'd0);
                chk("bubble_memread", 64'(ex_memread), 64'd0);
            end
        end
    end

    // Driver tasks
    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr,
                          input logic [63:0] d1, input logic [63:0] d2);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_regwrite = rw; id_memread = mr; rf_data1 = d1; rf_data2 = d2;
    endtask

    task automatic set_exmem(input logic rw, input logic mr, input logic [4:0] rd,
                             input logic [63:0] res);
        exmem_regwrite = rw; exmem_memread = mr; exmem_rd = rd; exmem_result = res;
    endtask

    task automatic set_memwb(input logic rw, input logic [4:0] rd, input logic [63:0] data);
        memwb_regwrite = rw; memwb_rd = rd; memwb_data = data;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0);
        set_exmem(1'b0, 1'b0, 5'd0, 64'd0);
        set_memwb(1'b0, 5'd0, 64'd0);
        flush = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 64'(ex_valid), 64'd0);
        chk({tag, "_opA"}, ex_opA, 64'd0);
        chk({tag, "_opB"}, ex_opB, 64'd0);
        chk({tag, "_rd"}, 64'(ex_rd), 64'd0);
        chk({tag, "_regwrite"}, 64'(ex_regwrite), 64'd0);
        chk({tag, "_memread"}, 64'(ex_memread), 64'd0);
    endtask

    // Reference model: in-order architectural state plus a tracked EX/MEM/WB pipeline
    logic [63:0] rf_m[32];
    logic [63:0] arch[32];
    bit          p_have;
    logic        p_v, p_u1, p_u2, p_rw, p_mr;
    logic [4:0]  p_rs1, p_rs2, p_rd;
    logic [63:0] p_res;
    logic        bx_v, bx_rw, bx_mr;
    logic [4:0]  bx_rd;
    logic [63:0] bx_val;
    logic        em_rw, em_mr;
    logic [4:0]  em_rd;
    logic [63:0] em_val;
    logic        mw_rw;
    logic [4:0]  mw_rd;
    logic [63:0] mw_val;

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [63:0] arch_val(input logic [4:0] rs);
        return (rs == 5'd31) ? 64'd0 : arch[rs];
    endfunction

    // A source is blocked if its producer is one ahead in EX or is a load still in MEM
    function automatic logic blocked(input logic used, input logic [4:0] rs);
        return used && (rs != 5'd31) &&
               ((bx_v && bx_rw && (bx_rd == rs)) || (em_rw && em_mr && (em_rd == rs)));
    endfunction

    initial begin
        logic exp_stall;
        logic take;

        idle();
        reset = 1'b0;
        #2;
        chk_reset_state("reset_init");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Plain pass
        @(negedge clk);
        set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 64'h11, 64'h22);
        #1 chk("plain_stall", 64'(stall), 64'd0);
        push_exp(5'd10, 1'b1, 1'b0, 64'h11, 64'h22, 1'b1, 1'b1);
        @(negedge clk); idle();
        @(negedge clk);

        // Double match on X5: EX/MEM wins, then MEM/WB alone
        set_id(1'b1, 5'd5, 5'd4, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 64'h55, 64'h22);
        set_exmem(1'b1, 1'b0, 5'd5, 64'hAAAA);
        set_memwb(1'b1, 5'd5, 64'hBBBB);
        #1 chk("dbl_stall", 64'(stall), 64'd0);
        push_exp(5'd6, 1'b1, 1'b0, 64'hAAAA, 64'h22, 1'b1, 1'b1);
        @(negedge clk);
        set_exmem(1'b0, 1'b0, 5'd5, 64'hAAAA);
        #1 chk("memwb_only_stall", 64'(stall), 64'd0);
        push_exp(5'd6, 1'b1, 1'b0, 64'hBBBB, 64'h22, 1'b1, 1'b1);
        @(negedge clk); idle();
        @(negedge clk);

        // ALU use: one stall cycle, retry forwards EX/MEM result
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 64'h1, 64'h2);
        #1 chk("alu_prod_stall", 64'(stall), 64'd0);
        push_exp(5'd7, 1'b1, 1'b0, 64'h1, 64'h2, 1'b1, 1'b1);
        @(negedge clk);
        set_id(1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 64'h777, 64'h88);
        #1 chk("alu_use_stall1", 64'(stall), 64'd1);
        @(negedge clk);
        set_exmem(1'b1, 1'b0, 5'd7, 64'h1234);
        #1 chk("alu_use_retry", 64'(stall), 64'd0);
        push_exp(5'd11, 1'b1, 1'b0, 64'h1234, 64'h88, 1'b1, 1'b1);
        @(negedge clk); idle();
        @(negedge clk);

        // Load use: two stall cycles, then MEM/WB forward
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 64'h10, 64'h20);
        #1 chk("load_prod_stall", 64'(stall), 64'd0);
        push_exp(5'd9, 1'b1, 1'b1, 64'h10, 64'h20, 1'b1, 1'b1);
        @(negedge clk);
        set_id(1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 64'h999, 64'h20);
        #1 chk("load_use_stall1", 64'(stall), 64'd1);
        @(negedge clk);
        set_exmem(1'b1, 1'b1, 5'd9, 64'h5555);
        #1 chk("load_use_stall2", 64'(stall), 64'd1);
        @(negedge clk);
        set_exmem(1'b0, 1'b0, 5'd0, 64'd0);
        set_memwb(1'b1, 5'd9, 64'hDEAD);
        #1 chk("load_use_go", 64'(stall), 64'd0);
        push_exp(5'd13, 1'b1, 1'b0, 64'hDEAD, 64'h20, 1'b1, 1'b1);
        @(negedge clk); idle();
        @(negedge clk);

        // X31 is never forwarded and never a hazard source
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 64'h1, 64'h2);
        #1 chk("x31_prod_stall", 64'(stall), 64'd0);
        push_exp(5'd31, 1'b1, 1'b0, 64'h1, 64'h2, 1'b1, 1'b1);
        @(negedge clk);
        set_id(1'b1, 5'd3, 5'd31, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 64'h33, 64'h99);
        set_exmem(1'b1, 1'b0, 5'd31, 64'hFF);
        #1 chk("x31_no_stall", 64'(stall), 64'd0);
        push_exp(5'd14, 1'b1, 1'b0, 64'h33, 64'h0, 1'b1, 1'b1);
        @(negedge clk); idle();
        @(negedge clk);

        // Flush together with a hazard
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 64'h1, 64'h2);
        #1 chk("flush_prod_stall", 64'(stall), 64'd0);
        push_exp(5'd12, 1'b1, 1'b0, 64'h1, 64'h2, 1'b1, 1'b1);
        @(negedge clk);
        set_id(1'b1, 5'd12, 5'd2, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 64'h12, 64'h2);
        flush = 1'b1;
        #1 chk("flush_haz_stall", 64'(stall), 64'd0);
        @(negedge clk); idle();
        chk("flush_kill_valid", 64'(ex_valid), 64'd0);
        @(negedge clk);

        // Asynchronous reset mid-stream
        set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd21, 1'b1, 1'b1, 64'hABC, 64'hDEF);
        push_exp(5'd21, 1'b1, 1'b1, 64'hABC, 64'hDEF, 1'b1, 1'b1);
        @(posedge clk);
        #3;
        idle();
        chk("pre_reset_valid", 64'(ex_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk_reset_state("reset_async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Random program against the architectural model
        for (int i = 0; i < 32; i++) begin
            rf_m[i] = {$urandom, $urandom};
            arch[i] = rf_m[i];
        end
        p_have = 1'b0;
        bx_v = 1'b0; bx_rw = 1'b0; bx_mr = 1'b0; bx_rd = 5'd0; bx_val = 64'd0;
        em_rw = 1'b0; em_mr = 1'b0; em_rd = 5'd0; em_val = 64'd0;
        mw_rw = 1'b0; mw_rd = 5'd0; mw_val = 64'd0;

        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (!p_have) begin
                p_v   = ($urandom_range(0, 9) != 0);
                p_rs1 = rand_reg();
                p_rs2 = rand_reg();
                p_u1  = ($urandom_range(0, 4) != 0);
                p_u2  = ($urandom_range(0, 2) != 0);
                p_rd  = rand_reg();
                p_mr  = ($urandom_range(0, 3) == 0);
                p_rw  = p_mr || ($urandom_range(0, 5) != 0);
                p_res = {$urandom, $urandom};
                p_have = 1'b1;
            end
            set_id(p_v, p_rs1, p_rs2, p_u1, p_u2, p_rd, p_rw, p_mr, rf_m[p_rs1], rf_m[p_rs2]);
            set_exmem(em_rw, em_mr, em_rd, em_mr ? {$urandom, $urandom} : em_val);
            set_memwb(mw_rw, mw_rd, mw_val);
            flush = ($urandom_range(0, 15) == 0);
            exp_stall = p_v && !flush && (blocked(p_u1, p_rs1) || blocked(p_u2, p_rs2));
            #1 chk("rand_stall", 64'(stall), 64'(exp_stall));
            take = p_v && !flush && !exp_stall;
            if (take) begin
                push_exp(p_rd, p_rw, p_mr, arch_val(p_rs1), arch_val(p_rs2), p_u1, p_u2);
                if (p_rw && (p_rd != 5'd31)) arch[p_rd] = p_res;
            end
            if (!exp_stall) p_have = 1'b0;
            @(posedge clk);
            if (mw_rw && (mw_rd != 5'd31)) rf_m[mw_rd] = mw_val;
            mw_rw = em_rw; mw_rd = em_rd; mw_val = em_val;
            em_rw = bx_v && bx_rw; em_mr = bx_v && bx_mr; em_rd = bx_rd; em_val = bx_val;
            bx_v = take; bx_rw = p_rw; bx_mr = p_mr; bx_rd = p_rd; bx_val = p_res;
        end

        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
